aria_mode_eng: RTL and testbench

- Parametrised block-cipher mode engine above the ARIA core. Drives the core's op/data/handshake ports.
- Adds per-channel CBC chaining and CTR counters to raw ECB, plus a valid/ready stream interface.
- NUM_CH independent contexts share one core, time-multiplexed one block at a time.

---
 rtl/aria_mode_pkg.sv | 29 ++
 rtl/aria_mode_ctx.sv | 65 ++++++
 rtl/aria_mode_eng.sv | 189 ++++++++++++++++++
 tb/tb_aria_mode_eng.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aria_mode_pkg.sv
// Shared constants for the ARIA mode engine: core op codes, modes, FSM states.
package aria_mode_pkg;

  localparam logic [2:0] K_ZERO    = 3'b000;
  localparam logic [2:0] K_SET128  = 3'b001;
  localparam logic [2:0] K_SET192  = 3'b010;
  localparam logic [2:0] K_SET256  = 3'b011;
  localparam logic [2:0] R_ENC_ECB = 3'b100;
  localparam logic [2:0] R_ENC_XFB = 3'b101;
  localparam logic [2:0] R_DEC_ECB = 3'b110;
  localparam logic [2:0] R_DEC_XFB = 3'b111;

  typedef enum logic [1:0] {
    M_ECB  = 2'b00,
    M_CBC  = 2'b01,
    M_CTR  = 2'b10,
    M_RSVD = 2'b11
  } mode_t;

  localparam logic [2:0] S_CLR    = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_KSTART = 3'd2;
  localparam logic [2:0] S_KWAIT  = 3'd3;
  localparam logic [2:0] S_LOAD   = 3'd4;
  localparam logic [2:0] S_START  = 3'd5;
  localparam logic [2:0] S_RWAIT  = 3'd6;
  localparam logic [2:0] S_OUT    = 3'd7;

endpackage

// File: rtl/aria_mode_ctx.sv
// Per-channel IV / chain / counter register file for the ARIA mode engine.
// Counter storage exists only when ARIA_MODE_CTR_EN is defined.
module aria_mode_ctx #(
  parameter int NUM_CH = 4,
  parameter int CTR_W  = 32,
  parameter int CHW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CHW-1:0] ch,
  input  logic           iv_wr,
  input  logic [CHW-1:0] iv_ch,
  input  logic [127:0]   iv_data,
  input  logic           chain_wr,
  input  logic [127:0]   chain_data,
  input  logic           ctr_inc,
  output logic [127:0]   chain,
  output logic [127:0]   ctr_blk
);

  logic [127:0] chain_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) chain_q[i] <= '0;
    end else if (iv_wr) begin
      chain_q[iv_ch] <= iv_data;
    end else if (chain_wr) begin
      chain_q[ch] <= chain_data;
    end
  end

  assign chain = chain_q[ch];

`ifdef ARIA_MODE_CTR_EN
  logic [127:0]     iv_q  [NUM_CH];
  logic [CTR_W-1:0] ctr_q [NUM_CH];

  // Only the low CTR_W bits count; the IV supplies the fixed upper part.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        iv_q[i]  <= '0;
        ctr_q[i] <= '0;
      end
    end else if (iv_wr) begin
      iv_q[iv_ch]  <= iv_data;
      ctr_q[iv_ch] <= iv_data[CTR_W-1:0];
    end else if (ctr_inc) begin
      ctr_q[ch] <= ctr_q[ch] + CTR_W'(1);
    end
  end

  if (CTR_W < 128) begin : g_part
    assign ctr_blk = {iv_q[ch][127:CTR_W], ctr_q[ch]};
  end else begin : g_full
    assign ctr_blk = ctr_q[ch];
  end
`else
  logic unused_ctr;
  assign unused_ctr = ctr_inc;
  assign ctr_blk = '0;
`endif

endmodule

// File: rtl/aria_mode_eng.sv
// ECB/CBC/CTR mode engine sharing one ARIA core across NUM_CH contexts.
// CTR mode is built only when ARIA_MODE_CTR_EN is defined.
module aria_mode_eng
  import aria_mode_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CTR_W  = 32,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_start,
  input  logic [1:0]     key_size,
  output logic           key_done,
  input  logic           iv_wr,
  input  logic [CHW-1:0] iv_ch,
  input  logic [127:0]   iv_data,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [127:0]   s_data,
  input  logic [CHW-1:0] s_ch,
  input  logic [1:0]     s_mode,
  input  logic           s_dec,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [127:0]   m_data,
  output logic [CHW-1:0] m_ch,
  output logic           m_err,
  output logic           idle_o,
  output logic [2:0]     aria_op,
  output logic           aria_en,
  output logic           aria_clr,
  output logic           ecb_en,
  output logic [127:0]   ecb_di,
  input  logic [127:0]   ecb_do,
  input  logic           k_ready,
  input  logic           r_ready
);

`ifdef ARIA_MODE_CTR_EN
  localparam bit CTR_ON = 1'b1;
`else
  localparam bit CTR_ON = 1'b0;
`endif

  logic [2:0]     state;
  logic [127:0]   dat;
  logic [CHW-1:0] ch;
  mode_t          mode;
  logic           dec;
  logic           saw_low;
  logic [1:0]     ksz;
  logic [127:0]   chain;
  logic [127:0]   ctr_blk;
  logic [127:0]   res;
  logic           capture;
  logic           use_dec;
  logic           bad_mode;

  assign idle_o   = state == S_IDLE;
  assign s_ready  = idle_o && !key_start;
  assign m_valid  = state == S_OUT;
  assign m_ch     = ch;
  assign aria_en  = state == S_KSTART || state == S_START;
  assign ecb_en   = state == S_LOAD;
  assign use_dec  = dec && mode != M_CTR;
  assign capture  = state == S_RWAIT && r_ready && saw_low;
  assign bad_mode = s_mode == M_RSVD || (s_mode == M_CTR && !CTR_ON);

  always_comb begin
    aria_op = K_ZERO;
    unique case (1'b1)
      state == S_KSTART: aria_op = {1'b0, ksz};
      state == S_START:  aria_op = use_dec ? R_DEC_ECB : R_ENC_ECB;
      default: ;
    endcase
  end

  always_comb begin
    ecb_di = '0;
    if (state == S_LOAD) begin
      case (mode)
        M_ECB:   ecb_di = dat;
        M_CBC:   ecb_di = dec ? dat : dat ^ chain;
        M_CTR:   ecb_di = ctr_blk;
        default: ecb_di = '0;
      endcase
    end
  end

  always_comb begin
    case (mode)
      M_ECB:   res = ecb_do;
      M_CBC:   res = dec ? ecb_do ^ chain : ecb_do;
      M_CTR:   res = dat ^ ecb_do;
      default: res = '0;
    endcase
  end

  // Context commits at capture, independent of output back-pressure.
  aria_mode_ctx #(
    .NUM_CH(NUM_CH),
    .CTR_W (CTR_W),
    .CHW   (CHW)
  ) u_ctx (
    .clk       (clk),
    .rst       (rst),
    .ch        (ch),
    .iv_wr     (iv_wr && idle_o),
    .iv_ch     (iv_ch),
    .iv_data   (iv_data),
    .chain_wr  (capture && mode == M_CBC),
    .chain_data(dec ? dat : ecb_do),
    .ctr_inc   (capture && mode == M_CTR),
    .chain     (chain),
    .ctr_blk   (ctr_blk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLR;
      aria_clr <= 1'b0;
      key_done <= 1'b0;
      m_data   <= '0;
      m_err    <= 1'b0;
      dat      <= '0;
      ch       <= '0;
      mode     <= M_ECB;
      dec      <= 1'b0;
      saw_low  <= 1'b0;
      ksz      <= '0;
    end else begin
      key_done <= 1'b0;
      aria_clr <= 1'b0;
      case (state)
        // First CLR cycle keeps outputs quiet; the second pulses aria_clr.
        S_CLR: begin
          if (!aria_clr) aria_clr <= 1'b1;
          else           state    <= S_IDLE;
        end
        S_IDLE: begin
          if (key_start) begin
            ksz   <= key_size;
            state <= S_KSTART;
          end else if (s_valid) begin
            dat   <= s_data;
            ch    <= s_ch;
            mode  <= mode_t'(s_mode);
            dec   <= s_dec;
            m_err <= bad_mode;
            if (bad_mode) begin
              m_data <= '0;
              state  <= S_OUT;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_KSTART: begin
          saw_low <= 1'b0;
          state   <= S_KWAIT;
        end
        S_KWAIT: begin
          if (!k_ready) begin
            saw_low <= 1'b1;
          end else if (saw_low) begin
            key_done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_LOAD:  state <= S_START;
        S_START: begin
          saw_low <= 1'b0;
          state   <= S_RWAIT;
        end
        S_RWAIT: begin
          if (!r_ready) begin
            saw_low <= 1'b1;
          end else if (saw_low) begin
            m_data <= res;
            state  <= S_OUT;
          end
        end
        S_OUT: if (m_ready) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aria_mode_eng.sv
// Directed bench for aria_mode_eng with a behavioural stand-in for the ARIA core.
module tb_aria_mode_eng;

  localparam int NUM_CH = 4;
  localparam int CTR_W  = 8;
  localparam int CHW    = 2;
  localparam int NV     = 11;

  logic           clk = 1'b0;
  logic           rst, key_start, key_done, iv_wr;
  logic [1:0]     key_size;
  logic [CHW-1:0] iv_ch, s_ch, m_ch;
  logic [127:0]   iv_data, s_data, m_data, ecb_di, ecb_do;
  logic           s_valid, s_ready, s_dec, m_valid, m_ready, m_err, idle_o;
  logic [1:0]     s_mode;
  logic [2:0]     aria_op;
  logic           aria_en, aria_clr, ecb_en, k_ready, r_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aria_mode_eng #(.NUM_CH(NUM_CH), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_size(key_size),
    .key_done(key_done), .iv_wr(iv_wr), .iv_ch(iv_ch), .iv_data(iv_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
    .s_mode(s_mode), .s_dec(s_dec), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_ch(m_ch), .m_err(m_err), .idle_o(idle_o),
    .aria_op(aria_op), .aria_en(aria_en), .aria_clr(aria_clr),
    .ecb_en(ecb_en), .ecb_di(ecb_di), .ecb_do(ecb_do),
    .k_ready(k_ready), .r_ready(r_ready)
  );

  // Stand-in cipher: E(x) = rotl8(x) ^ K, D(y) = rotr8(y ^ K).
  // K is chosen so that E(P0) equals the published ARIA-128 vector.
  logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] C0 = 128'hd718fbd6ab644c739da95f3be6451778;
  logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;
  logic [127:0] IV1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  logic [127:0] IV3 = 128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3cff;
  logic [127:0] K;

  function automatic logic [127:0] enc(input logic [127:0] x);
    return {x[119:0], x[127:120]} ^ K;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] y);
    logic [127:0] z;
    z = y ^ K;
    return {z[7:0], z[127:8]};
  endfunction

  logic [127:0] core_in;
  logic [2:0]   cop, key_op;
  logic         busy, key_set;
  int           cnt, en_cnt;

  initial begin
    k_ready = 1'b1; r_ready = 1'b1; ecb_do = '0; core_in = '0;
    busy = 1'b0; key_set = 1'b0; cnt = 0; en_cnt = 0; cop = '0; key_op = '0;
  end

  always @(posedge clk) begin
    if (ecb_en) core_in <= ecb_di;
    if (aria_en) begin
      en_cnt <= en_cnt + 1;
      cop    <= aria_op;
      cnt    <= 3;
      busy   <= 1'b1;
      if (aria_op[2]) r_ready <= 1'b0;
      else            k_ready <= 1'b0;
    end else if (busy) begin
      if (cnt == 0) begin
        busy    <= 1'b0;
        k_ready <= 1'b1;
        r_ready <= 1'b1;
        if (!cop[2]) begin
          key_set <= cop != 3'b000;
          key_op  <= cop;
        end else if (!key_set) ecb_do <= '0;
        else if (cop == 3'b100) ecb_do <= enc(core_in);
        else if (cop == 3'b110) ecb_do <= dec(core_in);
        else ecb_do <= '1;
      end else cnt <= cnt - 1;
    end
  end

  typedef struct {
    logic         wr_iv;
    logic [127:0] iv;
    logic [127:0] din;
    logic [1:0]   ch;
    logic [1:0]   mode;
    logic         dc;
    logic [127:0] exp;
    logic         exp_err;
  } vec_t;

  vec_t vt[NV];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {m_valid, s_ready, key_done, m_err, idle_o, aria_en,
                        aria_clr, ecb_en, aria_op, m_ch}, '0);
    chk({tag, "_m_data"}, m_data, '0);
    chk({tag, "_ecb_di"}, ecb_di, '0);
  endtask

  task automatic recv(output logic [127:0] od, output logic oe,
                      output logic [1:0] oc);
    int n = 0;
    while (!m_valid && n < 100) begin tick; n++; end
    chk("m_valid_seen", m_valid, 1);
    od = m_data; oe = m_err; oc = m_ch;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
  endtask

  task automatic xfer(input logic [127:0] d, input logic [1:0] c,
                      input logic [1:0] md, input logic dc,
                      output logic [127:0] od, output logic oe,
                      output logic [1:0] oc);
    int n = 0;
    s_data = d; s_ch = c; s_mode = md; s_dec = dc; s_valid = 1'b1;
    #1;
    while (!s_ready && n < 100) begin tick; n++; end
    chk("accept", s_ready, 1);
    tick;
    s_valid = 1'b0;
    recv(od, oe, oc);
  endtask

  task automatic write_iv(input logic [1:0] c, input logic [127:0] d);
    iv_wr = 1'b1; iv_ch = c; iv_data = d;
    tick;
    iv_wr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] od, c2, c7, d0;
    logic         oe;
    logic [1:0]   oc;
    int           n, e0, beats;

    K  = C0 ^ {P0[119:0], P0[127:120]};
    c2 = enc(P2 ^ C0);
    c7 = enc(P2 ^ IV1);
    vt[0]  = '{0, '0, C0, 0, 2'b00, 1, P0, 0};
    vt[1]  = '{0, '0, P2, 0, 2'b00, 0, enc(P2), 0};
    vt[2]  = '{0, '0, P0, 2, 2'b01, 0, C0, 0};
    vt[3]  = '{0, '0, P2, 2, 2'b01, 0, c2, 0};
    vt[4]  = '{1, '0, C0, 2, 2'b01, 1, P0, 0};
    vt[5]  = '{0, '0, c2, 2, 2'b01, 1, P2, 0};
    vt[6]  = '{0, '0, P2, 3, 2'b11, 0, '0, 1};
    vt[7]  = '{0, '0, P2, 1, 2'b01, 0, c7, 0};
`ifdef ARIA_MODE_CTR_EN
    vt[8]  = '{0, '0, P0, 3, 2'b10, 0, P0 ^ enc(IV3), 0};
    vt[9]  = '{0, '0, P2, 3, 2'b10, 0,
               P2 ^ enc({IV3[127:8], 8'h00}), 0};
    vt[10] = '{0, '0, P0, 3, 2'b10, 1,
               P0 ^ enc({IV3[127:8], 8'h01}), 0};
`else
    vt[8]  = '{0, '0, P0, 3, 2'b10, 0, '0, 1};
    vt[9]  = '{0, '0, P2, 3, 2'b10, 0, '0, 1};
    vt[10] = '{0, '0, P0, 3, 2'b10, 1, '0, 1};
`endif

    rst = 1'b1; key_start = 1'b0; key_size = 2'b00; iv_wr = 1'b0;
    iv_ch = '0; iv_data = '0; s_valid = 1'b0; s_data = '0; s_ch = '0;
    s_mode = '0; s_dec = 1'b0; m_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk_zero("reset");
    tick;
    chk("clr_pulse", {aria_clr, idle_o}, 2'b10);
    tick;
    chk("clr_done", {aria_clr, idle_o}, 2'b01);

    write_iv(1, IV1);
    write_iv(2, '0);
    write_iv(3, IV3);

    // key_start wins over a simultaneous block; the block waits for key_done
    key_size = 2'b01; key_start = 1'b1;
    s_valid = 1'b1; s_data = P0; s_ch = 0; s_mode = 2'b00; s_dec = 1'b0;
    #1;
    chk("s_ready_vs_key", s_ready, 0);
    tick;
    key_start = 1'b0;
    n = 0;
    while (!key_done && n < 100) begin
      if (s_ready) n = 1000;
      else begin tick; n++; end
    end
    chk("key_done", key_done, 1);
    chk("key_op", key_op, 3'b001);
    chk("accept_after_key", s_ready, 1);
    tick;
    s_valid = 1'b0;
    chk("key_done_pulse", key_done, 0);
    recv(od, oe, oc);
    chk("key_ecb_data", od, C0);
    chk("key_ecb_err", oe, 0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr_iv) write_iv(vt[i].ch, vt[i].iv);
      e0 = en_cnt;
      xfer(vt[i].din, vt[i].ch, vt[i].mode, vt[i].dc, od, oe, oc);
      chk($sformatf("v%0d_data", i), od, vt[i].exp);
      chk($sformatf("v%0d_err", i), oe, vt[i].exp_err);
      chk($sformatf("v%0d_ch", i), oc, vt[i].ch);
      if (vt[i].exp_err) chk($sformatf("v%0d_no_core", i), en_cnt - e0, 0);
    end

    // output held under back-pressure, no new block taken
    s_valid = 1'b1; s_data = P2; s_ch = 0; s_mode = 2'b00; s_dec = 1'b0;
    #1;
    chk("bp_accept", s_ready, 1);
    tick;
    s_data = P0;
    n = 0;
    while (!m_valid && n < 100) begin tick; n++; end
    d0 = enc(P2);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, d0);
      chk("bp_s_ready", s_ready, 0);
      tick;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk("bp_idle", idle_o, 1);

    // reset while the core is running
    s_valid = 1'b1; s_data = P0; s_ch = 1; s_mode = 2'b00;
    #1;
    tick;
    s_valid = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_zero("rwait_rst");
    tick;
    chk("rwait_clr", {aria_clr, idle_o}, 2'b10);
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (m_valid) beats++;
    end
    chk("rwait_no_beat", beats, 0);
    chk("rwait_idle", idle_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
